// File: rtl/llc_tag_array_if.sv
// Request/response bundle for the LLC tag array: one lookup/update request in,
// one response strobe with hit, way, prior MESI state and eviction details out.
interface llc_tag_array_if #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned N_WAY     = 8
);
  localparam int unsigned WAY_W = $clog2(N_WAY);

  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [ADDR_SIZE-1:0] req_addr;
  logic                 resp_valid;
  logic                 resp_hit;
  logic [WAY_W-1:0]     resp_way;
  logic [1:0]           resp_state;
  logic                 evict_valid;
  logic                 evict_dirty;
  logic [ADDR_SIZE-1:0] evict_addr;

  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_state,
           evict_valid, evict_dirty, evict_addr
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, resp_valid, resp_hit, resp_way, resp_state,
           evict_valid, evict_dirty, evict_addr
  );
endinterface

// File: rtl/llc_tag_array.sv
// N-way set-associative LLC tag store with per-line MESI state, tree pseudo-LRU
// replacement, and a one-set-per-cycle initialisation sweep after reset or CLEAR.
module llc_tag_array #(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned N_WAY      = 8,
  parameter int unsigned LINE_BYTES = 64
) (
  input logic             clk,
  input logic             rst,
  llc_tag_array_if.slave  bus
);
  localparam int unsigned OFFSET_SIZE = $clog2(LINE_BYTES);
  localparam int unsigned INDEX_SIZE  = $clog2(NUM_SETS);
  localparam int unsigned TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;
  localparam int unsigned WAY_W       = $clog2(N_WAY);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INVAL = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  logic [TAG_SIZE-1:0] tag_mem   [NUM_SETS][N_WAY];
  logic [1:0]          state_mem [NUM_SETS][N_WAY];
  logic [N_WAY-2:0]    plru_mem  [NUM_SETS];

  logic [1:0]            fsm_q;
  logic [INDEX_SIZE-1:0] cnt_q;

  logic [INDEX_SIZE-1:0] idx;
  logic [TAG_SIZE-1:0]   tag;
  logic                  unused_offset;
  logic                  accept;

  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic                  inv_any;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      plru_way;
  logic [WAY_W-1:0]      victim;
  logic [N_WAY-2:0]      plru_cur;
  int unsigned           node;

  logic                  upd_en;
  logic                  plru_en;
  logic [WAY_W-1:0]      upd_way;
  logic [1:0]            upd_state;
  logic [WAY_W-1:0]      r_way;
  logic [1:0]            r_state;
  logic                  ev_valid;
  logic                  ev_dirty;
  logic [ADDR_SIZE-1:0]  ev_addr;

  assign idx           = bus.req_addr[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE];
  assign tag           = bus.req_addr[ADDR_SIZE-1:OFFSET_SIZE+INDEX_SIZE];
  assign unused_offset = ^bus.req_addr[OFFSET_SIZE-1:0];
  assign accept        = (fsm_q == ST_IDLE) && bus.req_valid;
  assign plru_cur      = plru_mem[idx];

  assign bus.req_ready  = (fsm_q == ST_IDLE);
  assign bus.resp_valid = (fsm_q == ST_RESP);

  // Each tree node on the path to w is set to point into the sibling subtree.
  function automatic logic [N_WAY-2:0] plru_touch(input logic [N_WAY-2:0] p,
                                                  input logic [WAY_W-1:0] w);
    logic [N_WAY-2:0] r;
    int unsigned      n;
    logic             dir;
    r = p;
    n = 0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      dir  = w[WAY_W-1-l];
      r[n] = ~dir;
      n    = 2 * n + 1 + (dir ? 1 : 0);
    end
    return r;
  endfunction

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    inv_any  = 1'b0;
    inv_way  = '0;
    for (int unsigned i = 0; i < N_WAY; i++) begin
      if (!hit && state_mem[idx][i] != MESI_I && tag_mem[idx][i] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!inv_any && state_mem[idx][i] == MESI_I) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(i);
      end
    end
    node = 0;
    for (int unsigned l = 0; l < WAY_W; l++)
      node = 2 * node + 1 + (plru_cur[node] ? 1 : 0);
    plru_way = WAY_W'(node - (N_WAY - 1));
    victim   = inv_any ? inv_way : plru_way;
  end

  always_comb begin
    upd_en    = 1'b0;
    plru_en   = 1'b0;
    upd_way   = '0;
    upd_state = MESI_I;
    r_way     = '0;
    r_state   = hit ? state_mem[idx][hit_way] : MESI_I;
    ev_valid  = 1'b0;
    ev_dirty  = 1'b0;
    ev_addr   = '0;
    if (bus.req_op == OP_INVAL) begin
      upd_en    = hit;
      upd_way   = hit_way;
      upd_state = MESI_I;
      r_way     = hit ? hit_way : '0;
    end else if (bus.req_op != OP_CLEAR) begin
      upd_en  = 1'b1;
      plru_en = 1'b1;
      upd_way = hit ? hit_way : victim;
      r_way   = upd_way;
      if (bus.req_op == OP_WRITE)
        upd_state = MESI_M;
      else
        upd_state = hit ? state_mem[idx][hit_way] : MESI_E;
      if (!hit && state_mem[idx][victim] != MESI_I) begin
        ev_valid = 1'b1;
        ev_dirty = (state_mem[idx][victim] == MESI_M);
        ev_addr  = {tag_mem[idx][victim], idx, {OFFSET_SIZE{1'b0}}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q           <= ST_INIT;
      cnt_q           <= '0;
      bus.resp_hit    <= 1'b0;
      bus.resp_way    <= '0;
      bus.resp_state  <= MESI_I;
      bus.evict_valid <= 1'b0;
      bus.evict_dirty <= 1'b0;
      bus.evict_addr  <= '0;
    end else begin
      case (fsm_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == INDEX_SIZE'(NUM_SETS - 1))
            fsm_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            if (bus.req_op == OP_CLEAR) begin
              fsm_q <= ST_INIT;
              cnt_q <= '0;
            end else begin
              fsm_q           <= ST_RESP;
              bus.resp_hit    <= hit;
              bus.resp_way    <= r_way;
              bus.resp_state  <= r_state;
              bus.evict_valid <= ev_valid;
              bus.evict_dirty <= ev_dirty;
              bus.evict_addr  <= ev_addr;
            end
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  // Array contents need no reset: the INIT sweep rewrites every set before use.
  always_ff @(posedge clk) begin
    if (fsm_q == ST_INIT) begin
      for (int unsigned i = 0; i < N_WAY; i++) begin
        tag_mem[cnt_q][i]   <= '0;
        state_mem[cnt_q][i] <= MESI_I;
      end
      plru_mem[cnt_q] <= '0;
    end else if (accept) begin
      if (upd_en) begin
        tag_mem[idx][upd_way]   <= tag;
        state_mem[idx][upd_way] <= upd_state;
      end
      if (plru_en)
        plru_mem[idx] <= plru_touch(plru_cur, upd_way);
    end
  end
endmodule

// File: tb/tb_llc_tag_array.sv
// Directed scoreboard bench for llc_tag_array (16-bit addr, 4 sets, 4 ways, 16-byte lines).
module tb_llc_tag_array;
  typedef struct packed {
    logic        hit;
    logic [1:0]  way;
    logic [1:0]  st;
    logic        ev;
    logic        evd;
    logic [15:0] ea;
  } exp_t;

  localparam logic [1:0] RD = 2'd0, WR = 2'd1, IV = 2'd2, CL = 2'd3;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t expq[$];

  llc_tag_array_if #(.ADDR_SIZE(16), .N_WAY(4)) bus ();

  llc_tag_array #(.ADDR_SIZE(16), .NUM_SETS(4), .N_WAY(4), .LINE_BYTES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic h, input logic [1:0] w, input logic [1:0] s,
                              input logic e, input logic d, input logic [15:0] a);
    exp_t r;
    r.hit = h; r.way = w; r.st = s; r.ev = e; r.evd = d; r.ea = a;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every response strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      exp_t act, e;
      act = mk(bus.resp_hit, bus.resp_way, bus.resp_state,
               bus.evict_valid, bus.evict_dirty, bus.evict_addr);
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got %p, expected no response", act);
      end else begin
        e = expq.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL resp: got %p, expected %p", act, e);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] addr,
                      input logic push, input exp_t e);
    int n;
    if (push) expq.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no req_ready, expected req_ready within 50 cycles");
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (bus.req_ready !== 1'b1 && n < 20);
    check(name, n, 4);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {bus.req_ready, bus.resp_valid, bus.resp_hit, bus.resp_way, bus.resp_state,
                 bus.evict_valid, bus.evict_dirty, bus.evict_addr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = RD;
    bus.req_addr  = '0;

    // Reset and the initial sweep.
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_outputs");
    @(negedge clk) rst = 1'b0;
    wait_init("init_len_reset");

    // Fill then hit in set 3.
    send(RD, 16'h1230, 1'b1, mk(0, 2'd0, 2'd0, 0, 0, 16'h0000));
    check("resp_latency", bus.resp_valid, 1);
    @(posedge clk);
    #1 check("resp_one_cycle", {bus.resp_valid, bus.req_ready}, 2'b01);
    send(RD, 16'h1230, 1'b1, mk(1, 2'd0, 2'd2, 0, 0, 16'h0000));

    // CLEAR produces no response and reruns the sweep.
    send(CL, 16'h0000, 1'b0, '0);
    wait_init("init_len_clear");
    send(RD, 16'h1230, 1'b1, mk(0, 2'd0, 2'd0, 0, 0, 16'h0000));
    send(CL, 16'h0000, 1'b0, '0);
    wait_init("init_len_clear2");

    // Fill all four ways of set 3, then evict the dirty PLRU victim.
    send(WR, 16'h0030, 1'b1, mk(0, 2'd0, 2'd0, 0, 0, 16'h0000));
    send(RD, 16'h0130, 1'b1, mk(0, 2'd1, 2'd0, 0, 0, 16'h0000));
    send(RD, 16'h0230, 1'b1, mk(0, 2'd2, 2'd0, 0, 0, 16'h0000));
    send(RD, 16'h0330, 1'b1, mk(0, 2'd3, 2'd0, 0, 0, 16'h0000));
    send(RD, 16'h0430, 1'b1, mk(0, 2'd0, 2'd0, 1, 1, 16'h0030));

    // Invalidate, then an invalid way is preferred over the PLRU victim.
    send(IV, 16'h0230, 1'b1, mk(1, 2'd2, 2'd2, 0, 0, 16'h0000));
    send(RD, 16'h0530, 1'b1, mk(0, 2'd2, 2'd0, 0, 0, 16'h0000));
    send(RD, 16'h0030, 1'b1, mk(0, 2'd1, 2'd0, 1, 0, 16'h0130));
    send(WR, 16'h0330, 1'b1, mk(1, 2'd3, 2'd2, 0, 0, 16'h0000));
    send(RD, 16'h0330, 1'b1, mk(1, 2'd3, 2'd3, 0, 0, 16'h0000));
    send(IV, 16'h0730, 1'b1, mk(0, 2'd0, 2'd0, 0, 0, 16'h0000));
    send(WR, 16'h0000, 1'b1, mk(0, 2'd0, 2'd0, 0, 0, 16'h0000));

    // Reset during the response cycle kills the strobe at once.
    send(RD, 16'h0030, 1'b0, '0);
    check("resp_before_reset", bus.resp_valid, 1);
    rst = 1'b1;
    #1 check_outputs_zero("reset_mid_resp");
    @(negedge clk) rst = 1'b0;
    wait_init("init_len_reset2");
    send(RD, 16'h1230, 1'b1, mk(0, 2'd0, 2'd0, 0, 0, 16'h0000));
    send(RD, 16'h0030, 1'b1, mk(0, 2'd1, 2'd0, 0, 0, 16'h0000));

    repeat (4) @(posedge clk);
    #1 check("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/llc_tag_array.md
Name: llc_tag_array

Overview:
Parametrised N-way set-associative tag store for the last-level cache model, with a tree pseudo-LRU replacement engine and a per-line MESI state. It accepts one lookup/update request at a time over a valid/ready handshake. It returns hit/miss, way, prior state and eviction information. It also self-initialises every set after reset or on a CLEAR command.

Parameters:
ADDR_SIZE, 32, address width in bits.
NUM_SETS, 64, number of sets; power of two, at least 2.
N_WAY, 8, associativity; power of two, at least 2.
LINE_BYTES, 64, line size in bytes; OFFSET_SIZE = log2(LINE_BYTES), INDEX_SIZE = log2(NUM_SETS), TAG_SIZE = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request (IDLE state only).
req_op  in  2  operation code: 0 READ, 1 WRITE, 2 INVAL, 3 CLEAR.
req_addr  in  ADDR_SIZE  byte address; offset bits are ignored.
resp_valid  out  1  one-cycle response strobe.
resp_hit  out  1  tag matched a non-I line.
resp_way  out  log2(N_WAY)  way that was hit or filled.
resp_state  out  2  MESI state before the update: I=0, S=1, E=2, M=3.
evict_valid  out  1  a valid line was replaced; qualified by resp_valid.
evict_dirty  out  1  the replaced line was in state M.
evict_addr  out  ADDR_SIZE  line address of the replaced line, offset bits zero.

Behaviour:
- Address split: index = addr[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE]; tag = addr[ADDR_SIZE-1:OFFSET_SIZE+INDEX_SIZE].
- Per-set storage: N_WAY entries of {tag, state}, plus N_WAY-1 PLRU bits.
- FSM states: INIT, IDLE, RESP.
  - INIT: one set per cycle, set counter 0..NUM_SETS-1; writes state=I, tag=0, plru=0; req_ready=0. Moves to IDLE after set NUM_SETS-1.
  - IDLE: req_ready=1. On req_valid&&req_ready the lookup is combinational on the stored set. Array/PLRU update and response registers commit on that edge, then go to RESP. A CLEAR op goes to INIT with counter=0 and produces no response.
  - RESP: resp_valid=1 for exactly one cycle; req_ready=0; next state IDLE. Throughput is one request per 2 cycles; latency is accept edge to resp_valid high next cycle.
- Reset: while rst is high, or asynchronously on assertion, FSM goes to INIT with counter 0.
  - Outputs are 0 during reset: req_ready, resp_valid, resp_hit, resp_way, resp_state, evict_*.
  - Reset mid-RESP kills resp_valid immediately; the sweep restarts.
- Hit: tag match on a way with state != I. Multiple matches cannot occur by construction; lowest way wins if they do.
  - READ hit: state unchanged; PLRU touched.
  - WRITE hit: state to M; PLRU touched.
  - INVAL hit: state to I; PLRU not touched.
- Miss:
  - READ fills the line with state E; WRITE fills it with state M; PLRU touched on the filled way.
  - INVAL miss: no change; resp_way=0, evict_valid=0.
- Victim select: the lowest-numbered way in state I if any; otherwise the PLRU victim.
  - evict_valid=1 only when the victim state != I; evict_dirty = (victim state == M).
  - evict_addr = {victim tag, index, OFFSET_SIZE zeros}.
- PLRU tree: heap-ordered, node 0 is the root, children of node n are 2n+1 and 2n+2.
  - Bit=0 means the victim lies in the left (lower-way) subtree.
  - Victim walk: follow the bits from the root.
  - Touch of way w: set every node on the path so it points away from w.
- resp_state always reports the pre-update state, which is I on a miss.
- resp_* and evict_* hold their values after RESP until the next response; they are only meaningful while resp_valid=1.
- req_valid in INIT or RESP is ignored, since req_ready=0; the requester must hold the request until accepted.

Test Plan:
Configuration for all scenarios: ADDR_SIZE=16, NUM_SETS=4, N_WAY=4, LINE_BYTES=16, giving tag=addr[15:6] and index=addr[5:4].
1. Release rst -> req_ready=0 for exactly 4 cycles, then 1; all outputs 0 during reset.
2. READ 0x1230 -> resp_valid one cycle after accept, hit=0, way=0, state=I, evict_valid=0. Repeat READ 0x1230 -> hit=1, way=0, state=E.
3. Set 3: WRITE 0x0030, then READ 0x0130, 0x0230, 0x0330 (ways 0-3), then READ 0x0430 -> hit=0, way=0, evict_valid=1, evict_dirty=1, evict_addr=0x0030.
4. INVAL 0x0230 after scenario 3 -> hit=1, way=2, state=E. Then READ 0x0530 -> hit=0, way=2 (invalid preferred), evict_valid=0.
5. CLEAR issued mid-stream -> no resp_valid, req_ready=0 for 4 cycles; then READ of any previously resident address -> hit=0, state=I.
6. Assert rst during the RESP cycle -> resp_valid drops immediately (same cycle); after release the INIT sweep runs and a READ of 0x1230 misses.
